tile_order_shuffler: RTL and testbench
======================================

Name: tile_order_shuffler

Overview:
- Produces a random permutation of the board tile positions for a new Chicken Cha-Cha-Cha round.
- Drives the flat order bus, one IDX_W-bit slot per tile, that random_generator consumes as its tile-order source.
- Uses an internal Galois LFSR and an iterative Fisher-Yates shuffle over a register array.
- Latency is fixed, so game-FSM sequencing is deterministic.

Parameters:
- N_TILES, 24: number of tiles to permute; range 2..32.
- IDX_W, 5: bits per tile index; must satisfy 2^IDX_W >= N_TILES.
- LFSR_W, 16: LFSR width.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new shuffle; sampled only in IDLE or DONE.
- busy  out  1  high while INIT, DRAW or SWAP.
- done  out  1  one-cycle pulse on entering DONE.
- order_valid  out  1  high in DONE; order_flat holds a complete permutation.
- order_flat  out  N_TILES*IDX_W  slot k occupies bits [k*IDX_W +: IDX_W].

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - busy=0, done=0, order_valid=0.
  - All slots of order_flat are 0.
  - LFSR loads LFSR_SEED.
  - Index counter i is 0.
- LFSR: Galois, taps 16'hB400 for LFSR_W=16. Advances every clock after reset, in every state, and never reaches 0.
- States:
  - IDLE: start=1 -> INIT.
  - INIT, 1 cycle: slot k <= k for all k in parallel; i <= N_TILES-1; -> DRAW.
  - DRAW, 1 cycle:
    - cand = lfsr[IDX_W-1:0] & mask(i), where mask(i) = smallest 2^m-1 >= i.
    - j <= (cand > i) ? cand-(i+1) : cand. The result is always <= i; no rejection loop.
    - -> SWAP.
  - SWAP, 1 cycle: exchange slot i and slot j (j==i leaves the array unchanged); i <= i-1. If i==1 before the decrement -> DONE, else -> DRAW.
  - DONE:
    - done=1 for the entry cycle only; order_valid=1 while in DONE.
    - order_flat stays frozen.
    - start=1 -> INIT, and order_valid drops in the same edge.
- Latency: start sampled at edge t gives done=1 in cycle t+2+2*(N_TILES-1). For N_TILES=24 that is t+48.
- Rules:
  - start while busy is ignored and not queued.
  - order_flat changes only in INIT and SWAP; consumers must use it only while order_valid=1.
  - order_flat always holds each value 0..N_TILES-1 exactly once after INIT.
  - rst mid-shuffle aborts immediately to reset values. No partial permutation is flagged valid.
  - start held high continuously in DONE begins a new shuffle on the next edge.
- Width rules:
  - cand and j are IDX_W bits wide.
  - cand-(i+1) is computed only when cand > i, so no underflow occurs.
  - mask(i) is a combinational priority function of i.

Optional Feature:
- Macro SHUFFLER_SEED_CAPTURE_EN.
- Defined:
  - A free-running LFSR_W-bit cycle counter runs from reset.
  - On an accepted start, the LFSR loads lfsr ^ counter. If the result is 0, it loads LFSR_SEED instead.
  - Player button timing therefore becomes entropy.
- Undefined: no counter exists, and the sequence depends only on LFSR_SEED and cycles since reset.

Test Plan (macro undefined unless noted):
1. Assert rst for 3 cycles, then release -> busy=0, done=0, order_valid=0, order_flat=0. After INIT each slot k equals k.
2. Pulse start at cycle t with N_TILES=24 -> busy=1 from t+1; done pulses exactly at t+48; order_valid stays 1 afterwards; the 24 slots contain 0..23 each exactly once.
3. Pulse start again at t+20 during a shuffle -> no effect; done still at t+48 with a single pulse.
4. Assert rst at t+30 mid-shuffle -> busy=0 and order_valid=0 immediately; a new start at t+40 gives done at t+88 with a valid permutation.
5. Run two back-to-back shuffles from DONE -> both are valid permutations and the orders differ; the same start cycles after reset reproduce identical orders.
6. With SHUFFLER_SEED_CAPTURE_EN defined, run identical sequences whose start is issued 5 cycles later -> the permutations differ and both remain valid.

Source files
------------

// File: rtl/tile_order_shuffler.sv
// Random tile-order generator: Galois LFSR feeding an iterative Fisher-Yates shuffle.
// Optional macro SHUFFLER_SEED_CAPTURE_EN mixes a free-running cycle count into the LFSR on start.
module tile_order_shuffler #(
  parameter int                N_TILES   = 24,
  parameter int                IDX_W     = 5,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       order_valid,
  output logic [N_TILES*IDX_W-1:0]   order_flat
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_DRAW, S_SWAP, S_DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  slots [N_TILES];
  logic [IDX_W-1:0]  i_idx;
  logic [IDX_W-1:0]  j_idx;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  j_next;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_step;
  logic [LFSR_W-1:0] lfsr_next;
  logic              start_accept;

  // Smallest all-ones value that covers v, so masked draws stay close to range.
  function automatic logic [IDX_W-1:0] mask_of(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] m;
    m = '0;
    for (int b = 0; b < IDX_W; b++) begin
      if (m < v) m = (m << 1) | IDX_W'(1);
    end
    return m;
  endfunction

  assign start_accept = start && (state == S_IDLE || state == S_DONE);
  assign lfsr_step    = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

  // Folding the overshoot back below i keeps the draw to a single cycle.
  assign cand   = lfsr[IDX_W-1:0] & mask_of(i_idx);
  assign j_next = (cand > i_idx) ? (cand - i_idx - IDX_W'(1)) : cand;

`ifdef SHUFFLER_SEED_CAPTURE_EN
  logic [LFSR_W-1:0] cyc_cnt;
  logic [LFSR_W-1:0] lfsr_mix;

  assign lfsr_mix  = lfsr ^ cyc_cnt;
  assign lfsr_next = !start_accept     ? lfsr_step :
                     (lfsr_mix == '0)  ? LFSR_SEED : lfsr_mix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_cnt <= '0;
    else     cyc_cnt <= cyc_cnt + LFSR_W'(1);
  end
`else
  assign lfsr_next = lfsr_step;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      order_valid <= 1'b0;
      i_idx       <= '0;
      j_idx       <= '0;
      // NOTE: the slot array is deliberately reset; it is a small register file
      // whose contents are visible on order_flat, not an inferred RAM.
      for (int k = 0; k < N_TILES; k++) slots[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_INIT;
            busy  <= 1'b1;
          end
        end
        S_INIT: begin
          for (int k = 0; k < N_TILES; k++) slots[k] <= IDX_W'(k);
          i_idx <= IDX_W'(N_TILES - 1);
          state <= S_DRAW;
        end
        S_DRAW: begin
          j_idx <= j_next;
          state <= S_SWAP;
        end
        S_SWAP: begin
          // NOTE: non-blocking assignments read the old values on both sides,
          // so this is a true swap with no temporary (and a no-op when j == i).
          slots[i_idx] <= slots[j_idx];
          slots[j_idx] <= slots[i_idx];
          i_idx        <= i_idx - IDX_W'(1);
          if (i_idx == IDX_W'(1)) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            order_valid <= 1'b1;
          end else begin
            state <= S_DRAW;
          end
        end
        S_DONE: begin
          if (start) begin
            state       <= S_INIT;
            busy        <= 1'b1;
            order_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_TILES; k++) begin : g_flat
    assign order_flat[k*IDX_W +: IDX_W] = slots[k];
  end

endmodule

// File: tb/tb_tile_order_shuffler.sv
// Self-checking bench for tile_order_shuffler: vector table for the early cycles,
// then shuffle sequences checked against a scoreboard of model permutations.
module tb_tile_order_shuffler;

  localparam int N  = 24;
  localparam int W  = 5;
  localparam int LW = 16;
  localparam int FW = N * W;
  localparam logic [LW-1:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          order_valid;
  logic [FW-1:0] order_flat;

  int n_vec  = 0;
  int n_miss = 0;

  logic [FW-1:0] exp_q[$];
  logic [LW-1:0] m_lfsr;

  always #5 clk = ~clk;

  tile_order_shuffler #(
    .N_TILES(N), .IDX_W(W), .LFSR_W(LW), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .order_valid(order_valid), .order_flat(order_flat)
  );

  function automatic logic [LW-1:0] adv(input logic [LW-1:0] v);
    logic [LW-1:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference LFSR, advancing on every clock like the spec describes.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= adv(m_lfsr);
  end

  function automatic int mask_for(input int i);
    int m;
    m = 1;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  // l0 is the LFSR value right after the edge that accepted start.
  function automatic logic [FW-1:0] model_perm(input logic [LW-1:0] l0);
    int arr[N];
    int cand, j, t;
    logic [LW-1:0] l;
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) arr[k] = k;
    l = adv(l0);
    for (int i = N - 1; i >= 1; i--) begin
      cand = int'(l[W-1:0]) & mask_for(i);
      j = (cand > i) ? cand - i - 1 : cand;
      t = arr[i]; arr[i] = arr[j]; arr[j] = t;
      l = adv(adv(l));
    end
    f = '0;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'(arr[k]);
    return f;
  endfunction

  function automatic logic is_perm(input logic [FW-1:0] f);
    bit seen[32];
    int v;
    for (int k = 0; k < 32; k++) seen[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      v = int'(f[k*W +: W]);
      if (v >= N || seen[v]) return 1'b0;
      seen[v] = 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic [FW-1:0] ident_flat();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'(k);
    return f;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts a shuffle, optionally re-pulses start at cycle poke_at, and checks timing and order.
  task automatic do_shuffle(input string tag, input int poke_at, output logic [FW-1:0] got);
    int cyc, n_done, done_cyc;
    logic [FW-1:0] expv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(model_perm(m_lfsr));
    check({tag, "_busy_t1"}, busy, 1);
    check({tag, "_valid_t1"}, order_valid, 0);
    cyc = 1; n_done = 0; done_cyc = -1;
    while (cyc < 52) begin
      start = (cyc == poke_at);
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    start = 1'b0;
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_done_cycle"}, done_cyc, 48);
    check({tag, "_valid_hold"}, order_valid, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_is_perm"}, is_perm(order_flat), 1);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
`ifndef SHUFFLER_SEED_CAPTURE_EN
    check({tag, "_order"}, order_flat, expv);
`endif
    got = order_flat;
  endtask

  typedef enum {FL_ZERO, FL_IDENT, FL_ANY} flat_e;
  typedef struct {
    logic  start;
    logic  busy;
    logic  done;
    logic  valid;
    flat_e flat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] p1, p2, p3, pa;

    vecs[0] = '{start: 1'b0, busy: 1'b0, done: 1'b0, valid: 1'b0, flat: FL_ZERO};
    vecs[1] = '{start: 1'b0, busy: 1'b0, done: 1'b0, valid: 1'b0, flat: FL_ZERO};
    vecs[2] = '{start: 1'b1, busy: 1'b1, done: 1'b0, valid: 1'b0, flat: FL_ZERO};
    vecs[3] = '{start: 1'b0, busy: 1'b1, done: 1'b0, valid: 1'b0, flat: FL_IDENT};
    vecs[4] = '{start: 1'b1, busy: 1'b1, done: 1'b0, valid: 1'b0, flat: FL_ANY};
    vecs[5] = '{start: 1'b0, busy: 1'b1, done: 1'b0, valid: 1'b0, flat: FL_ANY};

    // Reset state and the first cycles of a shuffle.
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", order_valid, 0);
    check("rst_flat", order_flat, 0);
    for (int k = 0; k < 6; k++) begin
      start = vecs[k].start;
      @(negedge clk);
      check($sformatf("vec%0d_busy", k), busy, vecs[k].busy);
      check($sformatf("vec%0d_done", k), done, vecs[k].done);
      check($sformatf("vec%0d_valid", k), order_valid, vecs[k].valid);
      if (vecs[k].flat == FL_ZERO)  check($sformatf("vec%0d_flat0", k), order_flat, 0);
      if (vecs[k].flat == FL_IDENT) check($sformatf("vec%0d_ident", k), order_flat, ident_flat());
    end
    start = 1'b0;

    // Full shuffle with a stray start mid-run.
    do_reset();
    idle(4);
    do_shuffle("poke", 20, pa);

    // Reset in the middle of a shuffle, then a fresh one.
    do_reset();
    idle(2);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    idle(29);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", order_valid, 0);
    check("abort_done", done, 0);
    check("abort_flat", order_flat, 0);
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    idle(7);
    do_shuffle("after_abort", -1, pa);

    // Back-to-back shuffles and reproducibility from reset.
    do_reset();
    idle(4);
    do_shuffle("b2b_a", -1, p1);
    do_shuffle("b2b_b", -1, p2);
    check("b2b_differ", p1 != p2, 1);
    do_reset();
    idle(4);
    do_shuffle("repro", -1, p3);
    check("repro_same", p3, p1);

`ifdef SHUFFLER_SEED_CAPTURE_EN
    do_reset();
    idle(9);
    do_shuffle("late", -1, p2);
    check("seed_capture_differ", p1 != p2, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
